scope_trace_renderer: RTL and testbench
=======================================

// Module: scope_trace_renderer
// PURPOSE
//  Pixel source for the HDMI output path. Sits directly upstream of hdmi and replaces the debug test pattern.
//  - Captures a stream of 8-bit ADC samples into a ping-pong line buffer.
//  - Swaps buffers at frame boundaries.
//  - Renders the captured waveform as a continuous trace over a grid, aligned with the video timing it forwards.
// PARAMETERS
//  WIDTH      128       visible columns = samples per captured trace
//  HEIGHT     128       visible rows; power of 2, 2..256
//  GRID_DIV   16        grid line spacing in pixels; power of 2
// PORTS
//  pixclk           in   1   pixel clock, the only clock
//  rst              in   1   synchronous, active-high reset
//  sample_i         in   8   unsigned ADC sample
//  sample_valid_i   in   1   sample_i valid this cycle
//  sample_ready_o   out  1   renderer accepts a sample this cycle
//  counterX_i       in   10  current column from the timing generator
//  counterY_i       in   10  current row from the timing generator
//  hSync_i          in   1   timing input
//  vSync_i          in   1   timing input
//  drawArea_i       in   1   timing input
//  hSync_o          out  1   hSync_i delayed 2 cycles
//  vSync_o          out  1   vSync_i delayed 2 cycles
//  drawArea_o       out  1   drawArea_i delayed 2 cycles
//  red_o            out  8   pixel colour, aligned to drawArea_o
//  green_o          out  8   pixel colour, aligned to drawArea_o
//  blue_o           out  8   pixel colour, aligned to drawArea_o
// BEHAVIOUR
//  Reset
//   - All outputs 0. sample_ready_o = 0 while rst is high.
//   - Capture state = FILL, fill_idx = 0, disp_sel = 0 (fill buffer = 1), trace_valid = 0.
//   - A reset mid-capture discards the partial trace.
//  Capture FSM (states FILL, FULL)
//   - FILL: sample_ready_o = 1. A transfer occurs when valid && ready; it writes buf[~disp_sel][fill_idx] and increments fill_idx.
//   - Transfer at fill_idx == WIDTH-1 -> FULL, fill_idx = 0.
//   - FULL: sample_ready_o = 0; incoming samples are back-pressured, not dropped.
//   - Frame edge = vSync_i high while the registered previous vSync_i is low.
//   - Frame edge in FULL: disp_sel toggles, trace_valid = 1, state -> FILL. The new fill buffer is written from index 0.
//   - Frame edge in FILL: ignored. The display buffer and state are unchanged.
//   - Last transfer and frame edge in the same cycle: the write completes and the state becomes FULL. The swap waits for the next frame edge.
//  Render pipeline (latency exactly 2 pixclk, all outputs registered)
//   - Stage 1:
//     - Synchronous read of buf[disp_sel] at address counterX_i[log2(WIDTH)-1:0].
//     - Register counterX, counterY and the three timing inputs.
//   - Stage 2:
//     - lvl = rd_data >> (8 - log2(HEIGHT)).
//     - prv = lvl of the previous column. At column 0, prv = lvl.
//     - row = HEIGHT-1-counterY; row 0 is the bottom line.
//     - Trace pixel if trace_valid && min(prv,lvl) <= row <= max(prv,lvl).
//     - Else grid pixel if counterX%GRID_DIV == 0, or counterY%GRID_DIV == 0, or counterX == WIDTH-1, or counterY == HEIGHT-1.
//     - Else background.
//   - Colours: trace FF/FF/00, grid 40/40/40, background 00/00/00.
//   - When the stage-2 drawArea is 0, RGB = 0.
//   - A disp_sel toggle takes effect on the next read. A swap occurs at the vSync edge, so it is never mid-visible-frame.
//  Width rules
//   - Compare on 9-bit unsigned values.
//   - Columns >= WIDTH or rows >= HEIGHT never index the buffer (drawArea = 0 there).
// STRUCTURE
//  - Package scope_pkg:
//    - Colour constants TRACE_RGB, GRID_RGB, BG_RGB.
//    - Default WIDTH, HEIGHT and GRID_DIV.
//    - Capture state typedef {FILL, FULL}.
//  - Sub-module scope_line_ram:
//    - Simple dual-port RAM: 1 write port, 1 registered read port, depth WIDTH x 8.
//    - Instantiated twice, one per ping-pong half.
//  - The FSM, pipeline and compare logic live in this module.
// TESTING
//  1. Reset held 3 cycles, then released with no samples.
//     -> All RGB/sync outputs 0 during reset. sample_ready_o = 1 on the first cycle after release. Frame 0 shows grid only: (0,0) = 40/40/40, (1,1) = 0.
//  2. Stream 128 samples of value 0x80, then a frame edge.
//     -> sample_ready_o drops after the 128th transfer. The next frame has trace at row 64 only (counterY = 63), every column FF/FF/00.
//  3. Ramp sample[n] = 2n, n = 0..127.
//     -> In column n, lvl = n. Trace covers rows n-1..n (column 0: row 0 only). The pixel at counterY = 127-n is yellow.
//  4. Stop the stream at 100 samples and pulse vSync.
//     -> No swap occurs; the display still shows the old trace. Resume with 28 samples; the swap happens at the next vSync edge.
//  5. Make the 128th transfer coincide with the vSync rising edge.
//     -> The state goes FULL with no swap that frame. The swap occurs on the following edge.
//  6. Random valid gaps, plus rst asserted mid-fill at index 60.
//     -> Outputs return to 0 next cycle. trace_valid = 0. The refill starts at index 0. Timing outputs equal the inputs delayed 2 cycles throughout.

Source files
------------

// File: rtl/scope_trace_renderer_pkg.sv
// scope_pkg: shared colours, default geometry and capture state type for the scope renderer
package scope_pkg;
  localparam int DEF_WIDTH = 128;
  localparam int DEF_HEIGHT = 128;
  localparam int DEF_GRID_DIV = 16;
  localparam logic [23:0] TRACE_RGB = 24'hffff00;
  localparam logic [23:0] GRID_RGB = 24'h404040;
  localparam logic [23:0] BG_RGB = 24'h000000;
  typedef enum logic {FILL, FULL} cap_state_e;
endpackage

// File: rtl/scope_trace_renderer_line_ram.sv
// scope_line_ram: one ping-pong half, single write port and registered read port
module scope_line_ram #(
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  assign rdata = rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
endmodule

// File: rtl/scope_trace_renderer.sv
// scope_trace_renderer: captures ADC samples into a ping-pong line buffer and draws them as a trace over a grid
module scope_trace_renderer
  import scope_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int GRID_DIV = DEF_GRID_DIV
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  output logic       sample_ready_o,
  input  logic [9:0] counterX_i,
  input  logic [9:0] counterY_i,
  input  logic       hSync_i,
  input  logic       vSync_i,
  input  logic       drawArea_i,
  output logic       hSync_o,
  output logic       vSync_o,
  output logic       drawArea_o,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o
);
  localparam int AW = $clog2(WIDTH);
  localparam int HW = $clog2(HEIGHT);
  cap_state_e state_q, state_d;
  logic [AW-1:0] fill_idx_q, fill_idx_d;
  logic disp_sel_q, disp_sel_d, trace_valid_q, trace_valid_d;
  logic xfer, frame_edge, last;
  logic [7:0] rd0, rd1, rd_data;
  logic sel1_q, hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic [9:0] cx1_q, cy1_q;
  logic [8:0] lvl, prv, lvl_prev_q, row, lo, hi;
  logic trace_px, grid_px;
  logic [23:0] rgb_q, rgb_d;
  assign sample_ready_o = !rst && state_q == FILL;
  assign xfer = sample_valid_i && sample_ready_o;
  assign frame_edge = vSync_i && !vs1_q;
  assign last = fill_idx_q == AW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    fill_idx_d = fill_idx_q;
    disp_sel_d = disp_sel_q;
    trace_valid_d = trace_valid_q;
    if (xfer) begin
      fill_idx_d = last ? '0 : fill_idx_q + AW'(1);
      state_d = last ? FULL : FILL;
    end else if (state_q == FULL && frame_edge) begin
      state_d = FILL;
      disp_sel_d = !disp_sel_q;
      trace_valid_d = 1'b1;
    end
  end
  scope_line_ram #(.DEPTH(WIDTH)) u_ram0 (
    .clk(pixclk), .we(xfer && disp_sel_q), .waddr(fill_idx_q), .wdata(sample_i),
    .raddr(counterX_i[AW-1:0]), .rdata(rd0)
  );
  scope_line_ram #(.DEPTH(WIDTH)) u_ram1 (
    .clk(pixclk), .we(xfer && !disp_sel_q), .waddr(fill_idx_q), .wdata(sample_i),
    .raddr(counterX_i[AW-1:0]), .rdata(rd1)
  );
  always_comb begin
    rd_data = sel1_q ? rd1 : rd0;
    lvl = 9'(rd_data >> (8 - HW));
    prv = cx1_q == '0 ? lvl : lvl_prev_q;
    row = 9'(HEIGHT - 1) - cy1_q[8:0];
    lo = prv < lvl ? prv : lvl;
    hi = prv < lvl ? lvl : prv;
    trace_px = trace_valid_q && lo <= row && row <= hi;
    grid_px = (cx1_q & 10'(GRID_DIV - 1)) == '0 || (cy1_q & 10'(GRID_DIV - 1)) == '0 ||
              cx1_q == 10'(WIDTH - 1) || cy1_q == 10'(HEIGHT - 1);
    rgb_d = !de1_q ? 24'h0 : trace_px ? TRACE_RGB : grid_px ? GRID_RGB : BG_RGB;
  end
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q <= FILL;
      fill_idx_q <= '0;
      disp_sel_q <= 1'b0;
      trace_valid_q <= 1'b0;
      sel1_q <= 1'b0;
      cx1_q <= '0;
      cy1_q <= '0;
      {hs1_q, vs1_q, de1_q} <= '0;
      {hs2_q, vs2_q, de2_q} <= '0;
      lvl_prev_q <= '0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      fill_idx_q <= fill_idx_d;
      disp_sel_q <= disp_sel_d;
      trace_valid_q <= trace_valid_d;
      sel1_q <= disp_sel_q;
      cx1_q <= counterX_i;
      cy1_q <= counterY_i;
      {hs1_q, vs1_q, de1_q} <= {hSync_i, vSync_i, drawArea_i};
      {hs2_q, vs2_q, de2_q} <= {hs1_q, vs1_q, de1_q};
      lvl_prev_q <= lvl;
      rgb_q <= rgb_d;
    end
  end
  assign {hSync_o, vSync_o, drawArea_o} = {hs2_q, vs2_q, de2_q};
  assign {red_o, green_o, blue_o} = rgb_q;
endmodule

// File: tb/tb_scope_trace_renderer.sv
// tb_scope_trace_renderer: directed self-checking bench for the scope trace renderer
module tb_scope_trace_renderer;
  logic pixclk = 1'b0, rst = 1'b1;
  logic [7:0] sample_i = '0;
  logic sample_valid_i = 1'b0, sample_ready_o;
  logic [9:0] counterX_i = '0, counterY_i = '0;
  logic hSync_i = 1'b0, vSync_i = 1'b0, drawArea_i = 1'b0;
  logic hSync_o, vSync_o, drawArea_o;
  logic [7:0] red_o, green_o, blue_o;
  int n_chk = 0, n_pass = 0;
  logic [23:0] px;
  logic [2:0] pat [8] = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b110, 3'b011, 3'b100, 3'b001};
  localparam logic [23:0] YEL = 24'hffff00, GRY = 24'h404040, BLK = 24'h000000;
  scope_trace_renderer dut (
    .pixclk(pixclk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .counterX_i(counterX_i), .counterY_i(counterY_i),
    .hSync_i(hSync_i), .vSync_i(vSync_i), .drawArea_i(drawArea_i), .hSync_o(hSync_o),
    .vSync_o(vSync_o), .drawArea_o(drawArea_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
  );
  always #5 pixclk = ~pixclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask
  task automatic probe(input int x, input int y, output logic [23:0] rgb);
    drawArea_i = 1'b1;
    counterY_i = 10'(y);
    if (x > 0) begin
      counterX_i = 10'(x - 1);
      tick();
    end
    counterX_i = 10'(x);
    tick();
    {drawArea_i, counterX_i, counterY_i} = '0;
    tick();
    rgb = {red_o, green_o, blue_o};
  endtask
  task automatic send(input int n, input logic [7:0] base, input bit ramp, input bit vs_last, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!sample_ready_o && t < 1000) begin
        tick();
        t++;
      end
      if (t == 1000) begin
        chk("ready_wait", 0, 1);
        return;
      end
      sample_i = ramp ? 8'(2 * i) : base;
      sample_valid_i = 1'b1;
      vSync_i = vs_last && i == n - 1;
      tick();
      sample_valid_i = 1'b0;
      vSync_i = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic frame();
    vSync_i = 1'b1;
    tick();
    vSync_i = 1'b0;
    tick();
  endtask
  initial begin
    {hSync_i, vSync_i, drawArea_i} = 3'b111;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {hSync_o, vSync_o, drawArea_o, red_o, green_o, blue_o}, 0);
      chk("rst_ready", sample_ready_o, 0);
    end
    rst = 1'b0;
    {hSync_i, vSync_i, drawArea_i} = 3'b000;
    #1;
    chk("ready_after_rst", sample_ready_o, 1);
    for (int i = 0; i < 8; i++) begin
      {hSync_i, vSync_i, drawArea_i} = pat[i];
      tick();
      if (i > 0) chk("timing_delay", {hSync_o, vSync_o, drawArea_o}, pat[i-1]);
    end
    {hSync_i, vSync_i, drawArea_i} = 3'b000;
    tick();
    probe(0, 0, px);     chk("f0_grid_00", px, GRY);
    probe(1, 1, px);     chk("f0_bg_11", px, BLK);
    probe(127, 5, px);   chk("f0_grid_lastcol", px, GRY);
    probe(5, 127, px);   chk("f0_grid_lastrow", px, GRY);
    send(128, 8'h80, 0, 0, 0);
    chk("ready_full", sample_ready_o, 0);
    sample_valid_i = 1'b1;
    tick();
    chk("ready_backpressure", sample_ready_o, 0);
    sample_valid_i = 1'b0;
    frame();
    chk("ready_after_swap", sample_ready_o, 1);
    probe(10, 63, px);   chk("flat_trace", px, YEL);
    probe(0, 63, px);    chk("flat_col0", px, YEL);
    probe(127, 63, px);  chk("flat_lastcol", px, YEL);
    probe(10, 64, px);   chk("flat_grid", px, GRY);
    probe(10, 62, px);   chk("flat_bg", px, BLK);
    send(128, 8'h00, 1, 0, 0);
    frame();
    probe(50, 77, px);   chk("ramp_row_n", px, YEL);
    probe(50, 78, px);   chk("ramp_row_nm1", px, YEL);
    probe(50, 76, px);   chk("ramp_row_np1", px, BLK);
    probe(0, 127, px);   chk("ramp_col0_row0", px, YEL);
    probe(0, 126, px);   chk("ramp_col0_row1", px, GRY);
    probe(127, 0, px);   chk("ramp_lastcol", px, YEL);
    send(100, 8'h20, 0, 0, 0);
    frame();
    chk("partial_ready", sample_ready_o, 1);
    probe(50, 77, px);   chk("partial_no_swap", px, YEL);
    send(28, 8'h20, 0, 0, 0);
    chk("resume_full", sample_ready_o, 0);
    frame();
    probe(50, 111, px);  chk("resume_swap", px, YEL);
    probe(50, 77, px);   chk("resume_old_gone", px, BLK);
    send(128, 8'hfe, 0, 1, 0);
    chk("coincide_full", sample_ready_o, 0);
    probe(50, 0, px);    chk("coincide_no_swap", px, GRY);
    probe(50, 111, px);  chk("coincide_old", px, YEL);
    frame();
    probe(50, 0, px);    chk("coincide_swap", px, YEL);
    send(60, 8'h00, 0, 0, 1);
    {hSync_i, drawArea_i, counterX_i, counterY_i} = {1'b1, 1'b1, 10'd0, 10'd0};
    tick();
    tick();
    chk("pre_rst_pixel", {hSync_o, drawArea_o, red_o, green_o, blue_o}, {2'b11, YEL});
    rst = 1'b1;
    tick();
    chk("midrst_outputs", {hSync_o, vSync_o, drawArea_o, red_o, green_o, blue_o}, 0);
    chk("midrst_ready", sample_ready_o, 0);
    rst = 1'b0;
    {hSync_i, drawArea_i} = 2'b00;
    tick();
    probe(50, 0, px);    chk("rst_trace_invalid", px, GRY);
    send(128, 8'h00, 1, 0, 1);
    frame();
    probe(50, 77, px);   chk("refill_from_0", px, YEL);
    probe(100, 27, px);  chk("refill_col100", px, YEL);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
